microwave_panel_ctrl: RTL and testbench



---
 rtl/microwave_panel_ctrl.sv | 163 ++++++++++++++++
 tb/tb_microwave_panel_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/microwave_panel_ctrl.sv
// rtl/microwave_panel_ctrl.sv - microwave front-panel controller (optional KEY_ACCUM_EN: accumulate keys in SET)
module microwave_panel_ctrl #(
  parameter int W           = 4,
  parameter int BEEP_CYCLES = 8,
  parameter int START_TMO   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [W-1:0] key_val,
  input  logic         start,
  input  logic         stop,
  input  logic         door_open,
  input  logic         p,
  output logic [W-1:0] tin,
  output logic         r,
  output logic         beep,
  output logic [2:0]   state,
  output logic         err
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam int TW = $clog2(START_TMO + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        st_q;
  logic          p_q;
  logic          p_seen;
  logic [W-1:0]  rem;
  logic [W-1:0]  rem_dec;
  logic [BW-1:0] beep_cnt;
  logic [TW-1:0] wait_cnt;
  logic          p_fall;

  assign p_fall  = p_q & ~p;
  // Remaining time after this cycle's tick, saturating at zero.
  assign rem_dec = (p && rem != '0) ? rem - W'(1) : rem;
  assign state   = st_q;

`ifdef KEY_ACCUM_EN
  logic [W:0]   key_sum;
  logic [W-1:0] key_next;
  assign key_sum  = {1'b0, tin} + {1'b0, key_val};
  assign key_next = key_sum[W] ? '1 : key_sum[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      tin      <= '0;
      r        <= 1'b0;
      beep     <= 1'b0;
      err      <= 1'b0;
      rem      <= '0;
      p_q      <= 1'b0;
      p_seen   <= 1'b0;
      beep_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      p_q <= p;
      err <= 1'b0;
      rem <= rem_dec;
      case (st_q)
        IDLE: begin
          r    <= 1'b0;
          beep <= 1'b0;
          if (key_valid && key_val != '0) begin
            st_q <= SET;
            tin  <= key_val;
          end else begin
            tin <= '0;
          end
        end
        SET: begin
          r <= 1'b0;
          if (stop) begin
            st_q <= IDLE;
            tin  <= '0;
          end else if (start && !door_open) begin
            st_q     <= COOK;
            r        <= 1'b1;
            rem      <= tin;
            wait_cnt <= '0;
            p_seen   <= 1'b0;
          end else if (key_valid) begin
`ifdef KEY_ACCUM_EN
            tin <= key_next;
`else
            tin <= key_val;
            if (key_val == '0) st_q <= IDLE;
`endif
          end
        end
        COOK: begin
          if (p) p_seen <= 1'b1;
          if (p_fall) begin
            st_q     <= DONE;
            r        <= 1'b0;
            rem      <= '0;
            beep     <= 1'b1;
            beep_cnt <= '0;
          end else if (stop || door_open) begin
            st_q <= PAUSE;
            r    <= 1'b0;
            tin  <= rem_dec;
          end else if (!p_seen && !p) begin
            // Timer never started: abort once the allowance is used up.
            if (wait_cnt == TW'(START_TMO - 1)) begin
              st_q <= IDLE;
              tin  <= '0;
              r    <= 1'b0;
              err  <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
        end
        PAUSE: begin
          r <= 1'b0;
          if (stop) begin
            st_q <= IDLE;
            tin  <= '0;
          end else if (start && !door_open && rem != '0) begin
            st_q     <= COOK;
            r        <= 1'b1;
            tin      <= rem;
            rem      <= rem;
            wait_cnt <= '0;
            p_seen   <= 1'b0;
          end else if (rem == '0) begin
            st_q     <= DONE;
            beep     <= 1'b1;
            beep_cnt <= '0;
          end
        end
        DONE: begin
          r <= 1'b0;
          if (stop || beep_cnt == BW'(BEEP_CYCLES - 1)) begin
            st_q <= IDLE;
            beep <= 1'b0;
            tin  <= '0;
          end else begin
            beep_cnt <= beep_cnt + BW'(1);
          end
        end
        default: begin
          st_q <= IDLE;
          r    <= 1'b0;
          beep <= 1'b0;
          tin  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_panel_ctrl.sv
// tb/tb_microwave_panel_ctrl.sv - table-driven bench for microwave_panel_ctrl
module tb_microwave_panel_ctrl;

  logic       clk = 1'b0;
  logic       rst, key_valid, start, stop, door_open, p;
  logic [3:0] key_val;
  logic [3:0] tin;
  logic       r, beep, err;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  microwave_panel_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_val(key_val),
    .start(start), .stop(stop), .door_open(door_open), .p(p),
    .tin(tin), .r(r), .beep(beep), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, kv;
    logic [3:0] kval;
    logic       st, sp, dr, pp;
    logic [2:0] es;
    logic [3:0] et;
    logic       er, eb, ee;
  } vec_t;

  vec_t vq[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

  task automatic add(input logic rs, input logic kv, input logic [3:0] kval,
                     input logic st, input logic sp, input logic dr, input logic pp,
                     input logic [2:0] es, input logic [3:0] et,
                     input logic er, input logic eb, input logic ee);
    vec_t v;
    v.rst = rs; v.kv = kv; v.kval = kval; v.st = st; v.sp = sp; v.dr = dr; v.pp = pp;
    v.es = es; v.et = et; v.er = er; v.eb = eb; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic kv, input logic [3:0] kval,
                     input logic st, input logic sp, input logic dr, input logic pp);
    rst = rs; key_valid = kv; key_val = kval; start = st; stop = sp; door_open = dr; p = pp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int beeps;
    int guard;
    logic [3:0] set_zero_tin;
    logic [2:0] set_zero_st;
    logic [3:0] acc_tin;

`ifdef KEY_ACCUM_EN
    set_zero_st = S_SET;  set_zero_tin = 4'd3; acc_tin = 4'd15;
`else
    set_zero_st = S_IDLE; set_zero_tin = 4'd0; acc_tin = 4'd9;
`endif

    // reset state, key 0 ignored in IDLE
    add(1,0,0, 0,0,0,0, S_IDLE,0, 0,0,0);
    add(0,1,0, 0,0,0,0, S_IDLE,0, 0,0,0);
    // load and cook: key 5, p high 5 cycles, then 8 beep cycles
    add(0,1,5, 0,0,0,0, S_SET,5, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,5, 1,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0, 0,0,0,1, S_COOK,5, 1,0,0);
    add(0,0,0, 0,0,0,0, S_DONE,5, 0,1,0);
    for (int i = 0; i < 7; i++) add(0,0,0, 0,0,0,0, S_DONE,5, 0,1,0);
    add(0,0,0, 0,0,0,0, S_IDLE,0, 0,0,0);
    // pause/resume: key 9, door opens on third p-high cycle
    add(0,1,9, 0,0,0,0, S_SET,9, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,9, 1,0,0);
    add(0,0,0, 0,0,0,1, S_COOK,9, 1,0,0);
    add(0,0,0, 0,0,0,1, S_COOK,9, 1,0,0);
    add(0,0,0, 0,0,1,1, S_PAUSE,6, 0,0,0);
    add(0,0,0, 0,0,0,0, S_PAUSE,6, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,6, 1,0,0);
    for (int i = 0; i < 6; i++) add(0,0,0, 0,0,0,1, S_COOK,6, 1,0,0);
    add(0,0,0, 0,0,0,0, S_DONE,6, 0,1,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);
    // p_fall beats stop
    add(0,1,2, 0,0,0,0, S_SET,2, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,2, 1,0,0);
    add(0,0,0, 0,0,0,1, S_COOK,2, 1,0,0);
    add(0,0,0, 0,1,0,0, S_DONE,2, 0,1,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);
    // stop beats start in SET
    add(0,1,7, 0,0,0,0, S_SET,7, 0,0,0);
    add(0,0,0, 1,1,0,0, S_IDLE,0, 0,0,0);
    // door interlock, then stop to PAUSE, held stop to IDLE, held start stays IDLE
    add(0,1,3, 0,0,0,0, S_SET,3, 0,0,0);
    for (int i = 0; i < 10; i++) add(0,0,0, 1,0,1,0, S_SET,3, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,3, 1,0,0);
    add(0,0,0, 0,1,0,0, S_PAUSE,3, 0,0,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);
    add(0,0,0, 1,0,0,0, S_IDLE,0, 0,0,0);
    // start timeout
    add(0,1,4, 0,0,0,0, S_SET,4, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,4, 1,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0,0, S_COOK,4, 1,0,0);
    add(0,0,0, 0,0,0,0, S_IDLE,0, 0,0,1);
    add(0,0,0, 0,0,0,0, S_IDLE,0, 0,0,0);
    // reset mid-COOK
    add(0,1,6, 0,0,0,0, S_SET,6, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,6, 1,0,0);
    add(0,0,0, 0,0,0,1, S_COOK,6, 1,0,0);
    add(1,0,0, 0,0,0,1, S_IDLE,0, 0,0,0);
    add(0,0,0, 0,0,0,0, S_IDLE,0, 0,0,0);
    // keys 9 then 9
    add(0,1,9, 0,0,0,0, S_SET,9, 0,0,0);
    add(0,1,9, 0,0,0,0, S_SET,acc_tin, 0,0,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);
    // key 0 while in SET
    add(0,1,3, 0,0,0,0, S_SET,3, 0,0,0);
    add(0,1,0, 0,0,0,0, set_zero_st,set_zero_tin, 0,0,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);
    // stop as remaining reaches zero, PAUSE with rem=0 goes to DONE
    add(0,1,1, 0,0,0,0, S_SET,1, 0,0,0);
    add(0,0,0, 1,0,0,0, S_COOK,1, 1,0,0);
    add(0,0,0, 0,1,0,1, S_PAUSE,0, 0,0,0);
    add(0,0,0, 0,0,0,0, S_DONE,0, 0,1,0);
    add(0,0,0, 0,1,0,0, S_IDLE,0, 0,0,0);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].kv, vq[i].kval, vq[i].st, vq[i].sp, vq[i].dr, vq[i].pp);
      chk("state", i, {5'd0, state}, {5'd0, vq[i].es});
      chk("tin",   i, {4'd0, tin},   {4'd0, vq[i].et});
      chk("r",     i, {7'd0, r},     {7'd0, vq[i].er});
      chk("beep",  i, {7'd0, beep},  {7'd0, vq[i].eb});
      chk("err",   i, {7'd0, err},   {7'd0, vq[i].ee});
    end

    // beep length measured independently: key 1, cook one cycle, count beep-high cycles
    cyc(0,1,1, 0,0,0,0);
    cyc(0,0,0, 1,0,0,0);
    cyc(0,0,0, 0,0,0,1);
    cyc(0,0,0, 0,0,0,0);
    beeps = 0;
    guard = 0;
    while (beep === 1'b1 && guard < 50) begin
      beeps++;
      guard++;
      cyc(0,0,0, 0,0,0,0);
    end
    chk("beep_len", 0, 8'(beeps), 8'd8);
    chk("after_beep_state", 0, {5'd0, state}, {5'd0, S_IDLE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
